xpb_reduce_seq: RTL and testbench



---
 rtl/xpb_reduce_seq.sv | 73 +++++++
 tb/tb_xpb_reduce_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/xpb_reduce_seq.sv
// xpb_reduce_seq: walks upper-bit windows through the xpb table bank and accumulates lo + sum of xpb values
module xpb_reduce_seq #(
  parameter int WIN_W = 5,
  parameter int NUM_WIN = 8,
  parameter int XPB_W = 1024,
  parameter int LO_W = 1024,
  parameter int ACC_W = 1028,
  localparam int SW = NUM_WIN > 1 ? $clog2(NUM_WIN) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_WIN*WIN_W-1:0] in_hi,
  input  logic [LO_W-1:0]          in_lo,
  output logic [SW-1:0]            lut_sel,
  output logic [WIN_W-1:0]         lut_data,
  input  logic [XPB_W-1:0]         lut_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [SW-1:0] LAST = SW'(NUM_WIN - 1);
  state_t                   state;
  logic [ACC_W-1:0]         acc;
  logic [SW-1:0]            idx;
  logic [NUM_WIN*WIN_W-1:0] hi_r;
  logic [1:0]               pend;
  assign out_sum = acc;
  // pend[0]: table select registered last cycle; pend[1]: its lut_rdata is valid now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      lut_sel   <= '0;
      lut_data  <= '0;
      acc       <= '0;
      idx       <= '0;
      hi_r      <= '0;
      pend      <= '0;
    end else begin
      pend <= {pend[0], state == ISSUE};
      if (pend[1]) acc <= acc + ACC_W'(lut_rdata);
      case (state)
        IDLE: if (in_valid) begin
          hi_r     <= in_hi;
          acc      <= ACC_W'(in_lo);
          idx      <= '0;
          in_ready <= 1'b0;
          state    <= ISSUE;
        end
        ISSUE: begin
          lut_sel  <= idx;
          lut_data <= hi_r[idx*WIN_W +: WIN_W];
          idx      <= idx + 1'b1;
          if (idx == LAST) state <= DRAIN;
        end
        DRAIN: if (!pend[0]) begin
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xpb_reduce_seq.sv
// tb_xpb_reduce_seq: directed + random jobs against an arithmetic reference of lo + sum of table outputs
module tb_xpb_reduce_seq;
  localparam int WIN_W = 5;
  localparam int NUM_WIN = 8;
  localparam int XPB_W = 1024;
  localparam int LO_W = 1024;
  localparam int ACC_W = 1028;
  localparam int HW = NUM_WIN * WIN_W;
  localparam int SW = $clog2(NUM_WIN);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [HW-1:0]    in_hi = '0;
  logic [LO_W-1:0]  in_lo = '0;
  logic [SW-1:0]    lut_sel;
  logic [WIN_W-1:0] lut_data;
  logic [XPB_W-1:0] lut_rdata = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  bit               lut_const = 1'b0;
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               sel_log [0:63];

  xpb_reduce_seq #(.WIN_W(WIN_W), .NUM_WIN(NUM_WIN), .XPB_W(XPB_W), .LO_W(LO_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_hi(in_hi), .in_lo(in_lo),
    .lut_sel(lut_sel), .lut_data(lut_data), .lut_rdata(lut_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // registered table bank stand-in
  always @(posedge clk) lut_rdata <= lut_const ? {XPB_W{1'b1}} : XPB_W'((int'(lut_sel) + 1) * int'(lut_data));

  function automatic logic [ACC_W-1:0] model(logic [HW-1:0] hi, logic [LO_W-1:0] lo, bit cm);
    logic [ACC_W-1:0] s = ACC_W'(lo);
    for (int k = 0; k < NUM_WIN; k++)
      s = s + (cm ? ACC_W'({XPB_W{1'b1}}) : ACC_W'((k + 1) * int'(hi[k*WIN_W +: WIN_W])));
    return s;
  endfunction

  function automatic logic [LO_W-1:0] rand_lo();
    logic [LO_W-1:0] v;
    for (int i = 0; i < LO_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h..%0h exp=%0h..%0h", tag, got[ACC_W-1:ACC_W-64], got[127:0], exp[ACC_W-1:ACC_W-64], exp[127:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [HW-1:0] hi, input logic [LO_W-1:0] lo);
    int n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    check("in_ready_before_accept", ACC_W'(in_ready), ACC_W'(1));
    in_valid = 1'b1; in_hi = hi; in_lo = lo;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    sel_log[1] = int'(lut_sel);
    while (!out_valid && lat < 50) begin
      step();
      lat++;
      sel_log[lat] = int'(lut_sel);
    end
  endtask

  initial begin
    logic [HW-1:0]    hi;
    logic [LO_W-1:0]  lo;
    logic [ACC_W-1:0] exp_s, held;
    logic [ACC_W-1:0] q [$];
    int lat, nacc, guard, last_acc;
    bit go;
    // reset values
    step(); step();
    check("rst_in_ready", ACC_W'(in_ready), ACC_W'(1));
    check("rst_out_valid", ACC_W'(out_valid), ACC_W'(0));
    check("rst_out_sum", out_sum, '0);
    check("rst_lut_sel", ACC_W'(lut_sel), ACC_W'(0));
    check("rst_lut_data", ACC_W'(lut_data), ACC_W'(0));
    rst_n = 1'b1;
    step();
    // zero windows: sum = lo, fixed latency, one-cycle pulse
    accept('0, LO_W'(5));
    wait_valid(lat);
    check("zero_lat", ACC_W'(lat), ACC_W'(NUM_WIN + 3));
    check("zero_sum", out_sum, ACC_W'(5));
    step();
    check("zero_pulse_width", ACC_W'(out_valid), ACC_W'(0));
    check("zero_in_ready_back", ACC_W'(in_ready), ACC_W'(1));
    // all windows = 1: sum 36 and select walks 0..7 on consecutive cycles
    hi = 40'h0842108421;
    accept(hi, '0);
    wait_valid(lat);
    check("ones_sum", out_sum, ACC_W'(36));
    check("ones_model", out_sum, model(hi, '0, 1'b0));
    for (int k = 0; k < NUM_WIN; k++) check($sformatf("ones_sel%0d", k), ACC_W'(sel_log[k+2]), ACC_W'(k));
    step();
    // max operands through a constant all-ones table
    lut_const = 1'b1;
    lo = {LO_W{1'b1}};
    accept({HW{1'b1}}, lo);
    wait_valid(lat);
    exp_s = ACC_W'(lo) * ACC_W'(9);
    check("max_sum", out_sum, exp_s);
    check("max_model", out_sum, model({HW{1'b1}}, lo, 1'b1));
    step();
    lut_const = 1'b0;
    // random single jobs
    for (int j = 0; j < 3; j++) begin
      hi = {$urandom, $urandom};
      lo = rand_lo();
      accept(hi, lo);
      wait_valid(lat);
      check($sformatf("rand_lat%0d", j), ACC_W'(lat), ACC_W'(NUM_WIN + 3));
      check($sformatf("rand_sum%0d", j), out_sum, model(hi, lo, 1'b0));
      step();
    end
    // stall in DONE with in_valid pulses while busy
    out_ready = 1'b0;
    hi = {$urandom, $urandom};
    lo = rand_lo();
    accept(hi, lo);
    step(); step();
    in_valid = 1'b1; in_hi = {HW{1'b1}}; in_lo = LO_W'(999);
    step();
    check("busy_in_ready", ACC_W'(in_ready), ACC_W'(0));
    in_valid = 1'b0;
    wait_valid(lat);
    check("stall_sum", out_sum, model(hi, lo, 1'b0));
    held = out_sum;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i == 10);
      step();
      check($sformatf("stall_sum_hold%0d", i), out_sum, held);
      check($sformatf("stall_in_ready%0d", i), ACC_W'({in_ready, out_valid}), ACC_W'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("release_in_ready", ACC_W'(in_ready), ACC_W'(1));
    check("release_out_valid", ACC_W'(out_valid), ACC_W'(0));
    step(); step(); step();
    check("no_ghost_job", ACC_W'({in_ready, out_valid}), ACC_W'(2));
    // asynchronous reset mid-ISSUE
    accept(40'hFFFFFFFFFF, rand_lo());
    step(); step(); step();
    check("pre_rst_lut_data", ACC_W'(lut_data != 0), ACC_W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", ACC_W'(in_ready), ACC_W'(1));
    check("arst_out_valid", ACC_W'(out_valid), ACC_W'(0));
    check("arst_out_sum", out_sum, '0);
    check("arst_lut", ACC_W'({lut_sel, lut_data}), ACC_W'(0));
    step();
    rst_n = 1'b1;
    step();
    accept('0, LO_W'(7));
    wait_valid(lat);
    check("post_rst_sum", out_sum, ACC_W'(7));
    check("post_rst_lat", ACC_W'(lat), ACC_W'(NUM_WIN + 3));
    step();
    // back-to-back jobs with in_valid and out_ready held high
    nacc = 0; guard = 0; last_acc = 0;
    in_hi = {$urandom, $urandom};
    in_lo = rand_lo();
    while ((nacc < 4 || q.size() > 0) && guard < 200) begin
      if (out_valid) begin
        check($sformatf("b2b_sum%0d", nacc), out_sum, q.size() > 0 ? q.pop_front() : '1);
      end
      go = nacc < 4;
      in_valid = go;
      if (go && in_ready) begin
        q.push_back(model(in_hi, in_lo, 1'b0));
        if (nacc > 0) check($sformatf("b2b_spacing%0d", nacc), ACC_W'(cyc - last_acc), ACC_W'(NUM_WIN + 4));
        last_acc = cyc;
        nacc++;
      end
      step();
      if (go) begin
        in_hi = {$urandom, $urandom};
        in_lo = rand_lo();
      end
      guard++;
    end
    in_valid = 1'b0;
    check("b2b_completed", ACC_W'(guard < 200), ACC_W'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
